// File: rtl/user_irq_ctrl.sv
// user_irq_ctrl
// Interrupt controller in the user project area. Synchronises NSRC event
// sources, edge-detects each with a per-source polarity, latches events into
// pending bits and routes every enabled pending source onto one of the three
// user_irq lines into the management SoC. Firmware configures, inspects and
// acknowledges the block over a Wishbone slave port.
//
// Ports:
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   wbs_*                Wishbone slave (stb/cyc/we/sel/adr/dat_i in,
//                        ack/dat_o out)
//   irq_src_i[NSRC]      asynchronous interrupt sources
//   user_irq[3]          registered interrupt lines to the management SoC
//
// Register map (byte offset adr[7:0]):
//   0x00 PEND (R/W1C)  0x04 ENABLE  0x08 POL (1 = falling)
//   0x0C ROUTE (2 bits/source, 3 = unrouted)  0x10 SWSET (W)  0x14 STATUS
module user_irq_ctrl #(
  parameter int          NSRC     = 8,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          WARMUP   = 3
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [NSRC-1:0] irq_src_i,
  output logic [2:0]      user_irq
);

  localparam int WW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

  localparam logic [7:0] OFF_PEND   = 8'h00;
  localparam logic [7:0] OFF_ENABLE = 8'h04;
  localparam logic [7:0] OFF_POL    = 8'h08;
  localparam logic [7:0] OFF_ROUTE  = 8'h0C;
  localparam logic [7:0] OFF_SWSET  = 8'h10;
  localparam logic [7:0] OFF_STATUS = 8'h14;

  // Lowest-numbered set bit, 0 when none is set.
  function automatic logic [3:0] lowest_idx(input logic [NSRC-1:0] v);
    lowest_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = 4'(i);
    end
  endfunction

  logic [NSRC-1:0]   src_p1, src_p2, src_p3;
  logic [NSRC-1:0]   pend, enable, pol;
  logic [2*NSRC-1:0] route;
  logic [WW-1:0]     warm;
  logic              ack_q;
  logic [31:0]       rdat_q;
  logic [2:0]        irq_q;

  logic              hit, acc, wr;
  logic [7:0]        off;
  logic [31:0]       bmask, wd, rdata;
  logic [NSRC-1:0]   wd_n, m_n, rise, fall, evt, active, clr, set;
  logic [2*NSRC-1:0] wd_r, m_r;
  logic [2:0]        irq_d;
  logic              unused_bits;

  // Bus decode. A new access is accepted only while ack is low, so ack can
  // never be high on two consecutive cycles.
  assign hit   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign acc   = hit & ~ack_q;
  assign wr    = acc & wbs_we_i;
  assign off   = wbs_adr_i[7:0];
  assign bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                  {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wd    = wbs_dat_i & bmask;
  assign wd_n  = wd[NSRC-1:0];
  assign m_n   = bmask[NSRC-1:0];
  assign wd_r  = wd[2*NSRC-1:0];
  assign m_r   = bmask[2*NSRC-1:0];
  assign unused_bits = ^{wd, bmask};

  // Edge detection on the synchronised level; masked during warmup so a
  // source already high when reset releases does not look like a rise.
  assign rise   = src_p2 & ~src_p3;
  assign fall   = ~src_p2 & src_p3;
  assign evt    = (warm == '0) ? ((pol & fall) | (~pol & rise)) : '0;
  assign active = pend & enable;

  // A hardware event or SWSET in the same cycle as a W1C wins.
  assign clr = (wr && off == OFF_PEND)  ? wd_n : '0;
  assign set = ((wr && off == OFF_SWSET) ? wd_n : '0) | evt;

  always_comb begin
    irq_d = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (active[i] && route[2*i +: 2] == 2'(k)) irq_d[k] = 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_PEND:   rdata = 32'(pend);
      OFF_ENABLE: rdata = 32'(enable);
      OFF_POL:    rdata = 32'(pol);
      OFF_ROUTE:  rdata = 32'(route);
      OFF_STATUS: rdata = {|active, 27'd0, lowest_idx(active)};
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      src_p1 <= '0;
      src_p2 <= '0;
      src_p3 <= '0;
      pend   <= '0;
      enable <= '0;
      pol    <= '0;
      route  <= '0;
      warm   <= WW'(WARMUP);
      ack_q  <= 1'b0;
      rdat_q <= '0;
      irq_q  <= '0;
    end else begin
      // p1/p2: two-flop synchroniser, p3: history for edge detection
      src_p1 <= irq_src_i;
      src_p2 <= src_p1;
      src_p3 <= src_p2;
      if (warm != '0) warm <= warm - 1'b1;

      // register stage: writes land on the edge that raises ack
      pend <= (pend & ~clr) | set;
      if (wr && off == OFF_ENABLE) enable <= (enable & ~m_n) | wd_n;
      if (wr && off == OFF_POL)    pol    <= (pol & ~m_n) | wd_n;
      if (wr && off == OFF_ROUTE)  route  <= (route & ~m_r) | wd_r;
      ack_q  <= acc;
      rdat_q <= (acc && !wbs_we_i) ? rdata : '0;

      // output stage: user_irq follows PEND/ENABLE/ROUTE by one edge
      irq_q <= irq_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign user_irq  = irq_q;

endmodule

// File: tb/tb_user_irq_ctrl.sv
module tb_user_irq_ctrl;

  localparam int          NSRC = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_PEND = BASE + 32'h00, A_EN = BASE + 32'h04,
                          A_POL = BASE + 32'h08, A_ROUTE = BASE + 32'h0C,
                          A_SWSET = BASE + 32'h10, A_STAT = BASE + 32'h14;

  logic            clk = 1'b0;
  logic            rst;
  logic            stb, cyc, we;
  logic [3:0]      sel;
  logic [31:0]     adr, wdat;
  logic            ack;
  logic [31:0]     rdat;
  logic [NSRC-1:0] src;
  logic [2:0]      irq;

  int n_total = 0;
  int n_pass  = 0;

  user_irq_ctrl #(.NSRC(NSRC), .BASE_ADR(BASE), .WARMUP(3)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .irq_src_i(src),
    .user_irq (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Called at a negedge; returns at the negedge after the access ends.
  task automatic wb_acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic acked);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    acked = 1'b0;
    rd = '0;
    for (int c = 0; c < 4 && !acked; c++) begin
      tick();
      if (ack) begin
        acked = 1'b1;
        rd = rdat;
      end
    end
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    logic        k;
    wb_acc(1'b1, a, d, s, rd, k);
    check("write_ack", 32'(k), 32'd1);
  endtask

  task automatic wb_check_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        k;
    wb_acc(1'b0, a, 32'd0, 4'hF, rd, k);
    check({tag, "_ack"}, 32'(k), 32'd1);
    check(tag, rd, exp);
  endtask

  // Reference: which line each source drives, and which line set results.
  function automatic logic [2:0] model_irq(input logic [7:0] p, input logic [7:0] e,
                                           input logic [15:0] r);
    logic [2:0] v;
    v = '0;
    for (int i = 0; i < NSRC; i++) begin
      int line;
      line = (r >> (2 * i)) & 3;
      if (p[i] && e[i] && line < 3) v = v | 3'(1 << line);
    end
    return v;
  endfunction

  function automatic logic [31:0] model_status(input logic [7:0] p, input logic [7:0] e);
    logic [7:0] a;
    a = p & e;
    if (a == 0) return 32'd0;
    for (int i = 0; i < NSRC; i++) if (a[i]) return 32'h8000_0000 | 32'(i);
    return 32'd0;
  endfunction

  initial begin
    logic [31:0] rd;
    logic        k;
    logic [7:0]  r_pol, r_en, nxt, exp_pend;
    logic [15:0] r_route;

    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0;
    adr = '0; wdat = '0; src = '0;

    // Reset state
    ticks(3);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", rdat, 32'd0);
    @(negedge clk); rst = 1'b0;
    ticks(5);
    @(negedge clk);
    wb_check_read("rst_pend", A_PEND, 32'd0);
    wb_check_read("rst_route", A_ROUTE, 32'd0);

    // Rising edge on source 0 routed to line 0: PEND after E+2, irq after E+3
    wb_write(A_EN, 32'h01, 4'hF);
    wb_write(A_ROUTE, 32'h0, 4'hF);
    wb_write(A_POL, 32'h0, 4'hF);
    src[0] = 1'b1;
    tick();
    check("t1_irq_e0", 32'(irq), 32'd0);
    tick(); tick();
    check("t1_irq_e2", 32'(irq), 32'd0);
    tick();
    check("t1_irq_e3", 32'(irq), 32'd1);
    @(negedge clk);
    wb_check_read("t1_pend", A_PEND, 32'h01);
    wb_write(A_PEND, 32'h01, 4'hF);
    check("t1_irq_at_ack", 32'(irq), 32'd1);
    tick();
    check("t1_irq_cleared", 32'(irq), 32'd0);
    @(negedge clk); src[0] = 1'b0;

    // Falling polarity on source 3 routed to line 2
    wb_write(A_POL, 32'h08, 4'hF);
    wb_write(A_EN, 32'h08, 4'hF);
    wb_write(A_ROUTE, 32'h80, 4'hF);
    src[3] = 1'b1;
    ticks(3);
    @(negedge clk); src[3] = 1'b0;
    ticks(4);
    check("t2_irq", 32'(irq), 32'd4);
    @(negedge clk);
    wb_check_read("t2_status", A_STAT, 32'h8000_0003);
    wb_check_read("t2_pend", A_PEND, 32'h08);
    src[3] = 1'b1;
    ticks(4);
    @(negedge clk);
    wb_check_read("t2_pend_rise", A_PEND, 32'h08);
    wb_write(A_POL, 32'h00, 4'hF);
    src[3] = 1'b0;
    ticks(4);
    @(negedge clk);
    wb_write(A_PEND, 32'h08, 4'hF);
    wb_check_read("t2_pend_clr", A_PEND, 32'h00);
    check("t2_irq_clr", 32'(irq), 32'd0);

    // Pending latches while disabled; enabling later asserts irq
    wb_write(A_EN, 32'h00, 4'hF);
    wb_write(A_ROUTE, 32'h400, 4'hF);
    src[5] = 1'b1;
    ticks(4);
    check("t3_irq_dis", 32'(irq), 32'd0);
    @(negedge clk);
    wb_check_read("t3_pend", A_PEND, 32'h20);
    wb_write(A_EN, 32'h20, 4'hF);
    check("t3_irq_at_ack", 32'(irq), 32'd0);
    tick();
    check("t3_irq_en", 32'(irq), 32'd2);
    @(negedge clk);
    wb_write(A_ROUTE, 32'hC00, 4'hF);
    check("t3_irq_rt_ack", 32'(irq), 32'd2);
    tick();
    check("t3_irq_unrouted", 32'(irq), 32'd0);
    @(negedge clk);
    wb_write(A_PEND, 32'h20, 4'hF);
    src[5] = 1'b0;

    // Source held high through reset release: warmup suppresses it
    src[2] = 1'b1;
    rst = 1'b1;
    ticks(3);
    @(negedge clk); rst = 1'b0;
    ticks(10);
    check("t4_irq", 32'(irq), 32'd0);
    @(negedge clk);
    wb_check_read("t4_pend_warm", A_PEND, 32'h00);
    src[2] = 1'b0;
    ticks(3);
    @(negedge clk); src[2] = 1'b1;
    ticks(4);
    @(negedge clk);
    wb_check_read("t4_pend_edge", A_PEND, 32'h04);
    wb_write(A_PEND, 32'h04, 4'hF);
    src[2] = 1'b0;

    // Byte-lane gating
    wb_write(A_EN, 32'hFF, 4'b0001);
    wb_write(A_EN, 32'h00, 4'b1110);
    wb_check_read("sel_enable", A_EN, 32'hFF);
    wb_write(A_EN, 32'h00, 4'hF);

    // Hardware event and W1C on the same edge: set wins
    src[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    wb_write(A_PEND, 32'h02, 4'hF);
    wb_check_read("t5_set_wins", A_PEND, 32'h02);
    wb_write(A_SWSET, 32'h80, 4'hF);
    wb_check_read("t5_swset", A_PEND, 32'h82);
    wb_check_read("t5_swset_rd", A_SWSET, 32'h0);
    wb_write(A_PEND, 32'hFF, 4'h0);
    wb_check_read("t5_w1c_nosel", A_PEND, 32'h82);
    wb_write(A_PEND, 32'hFF, 4'hF);
    wb_check_read("t5_w1c_all", A_PEND, 32'h00);

    // Unmapped offset, out-of-window address, reset mid-access
    wb_check_read("t6_unmapped", BASE + 32'h1C, 32'h0);
    wb_acc(1'b0, BASE + 32'h100, 32'd0, 4'hF, rd, k);
    check("t6_nohit_ack", 32'(k), 32'd0);
    wb_write(A_EN, 32'h01, 4'hF);
    wb_write(A_SWSET, 32'h01, 4'hF);
    tick();
    check("t6_irq_before_rst", 32'(irq), 32'd1);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = A_PEND; sel = 4'hF;
    #2 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t6_rst_ack", 32'(ack), 32'd0);
      check("t6_rst_dat", rdat, 32'd0);
      check("t6_rst_irq", 32'(irq), 32'd0);
    end
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; rst = 1'b0;
    ticks(5);
    @(negedge clk);
    wb_check_read("t6_pend_after_rst", A_PEND, 32'h0);

    // Randomised rounds against the behavioural model
    for (int round = 0; round < 8; round++) begin
      r_pol   = 8'($urandom);
      r_en    = 8'($urandom);
      r_route = 16'($urandom);
      wb_write(A_POL, 32'(r_pol), 4'hF);
      wb_write(A_EN, 32'(r_en), 4'hF);
      wb_write(A_ROUTE, 32'(r_route), 4'hF);
      wb_write(A_PEND, 32'hFF, 4'hF);
      exp_pend = '0;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        nxt = 8'($urandom);
        for (int i = 0; i < NSRC; i++) begin
          if (r_pol[i] ? (src[i] && !nxt[i]) : (!src[i] && nxt[i])) exp_pend[i] = 1'b1;
        end
        src = nxt;
      end
      ticks(4);
      check("rnd_irq", 32'(irq), 32'(model_irq(exp_pend, r_en, r_route)));
      @(negedge clk);
      wb_check_read("rnd_pend", A_PEND, 32'(exp_pend));
      wb_check_read("rnd_status", A_STAT, model_status(exp_pend, r_en));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/user_irq_ctrl.md
Name: user_irq_ctrl

Overview:
Interrupt controller in the user project area that drives the three user_irq lines into the management SoC.
- Synchronises NSRC external/user-logic event sources and edge-detects each with per-source polarity.
- Latches events into pending bits and routes each enabled pending source to one of user_irq[2:0].
- Firmware configures, inspects and acknowledges it over the Wishbone slave port.

Parameters:
NSRC, 8, number of interrupt sources (1..16)
BASE_ADR, 32'h3000_0000, Wishbone base; block claims BASE_ADR[31:8] window
WARMUP, 3, cycles after reset release during which edge detection is suppressed

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  synchronous active-high reset
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte lane select
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
irq_src_i  in  NSRC  asynchronous interrupt sources
user_irq  out  3  interrupt lines to management SoC

Behaviour:
- Register map (offset adr[7:0]); upper unused bits read 0:
  - 0x00 PEND: R, W1C.
  - 0x04 ENABLE: RW.
  - 0x08 POL: RW; 0 = rising, 1 = falling.
  - 0x0C ROUTE: RW; 2 bits per source, i at [2i+1:2i]. Value 0..2 selects user_irq line; 3 = unrouted.
  - 0x10 SWSET: W; 1 sets PEND bit; reads 0.
  - 0x14 STATUS: R; [31] = any PEND&ENABLE; [3:0] = lowest index with PEND&ENABLE, else 0.
  - Other offsets: read 0, writes ignored, still acked.
- Wishbone:
  - Hit = stb & cyc & (adr[31:8]==BASE_ADR[31:8]).
  - ack_o pulses 1 cycle, registered, one cycle after hit is first seen. ack is never asserted two consecutive cycles, so each access costs at least 2 cycles.
  - Write side effects occur on the ack edge. dat_o is valid with ack and returns to 0 otherwise.
  - sel gates bytes for every writable register, including W1C and SWSET.
  - Non-hit: no ack, no side effect.
- Sync/edge path per source: 2-flop sync s1, s2, then history flop s3.
  - Rise = s2 & ~s3; fall = ~s2 & s3; event = POL ? fall : rise.
  - A source sampled at edge E sets PEND after edge E+2.
- user_irq[k] is registered: OR over i of PEND[i] & ENABLE[i] & (ROUTE[i]==k). It asserts one edge after the PEND/ENABLE/ROUTE change; total source-to-user_irq latency is 3 edges (high after edge E+3).
- Level semantics: user_irq stays high while any contributing bit remains. It deasserts the edge after the last contributor is cleared, disabled or rerouted.
- PEND latches regardless of ENABLE; enabling a stale pending bit asserts user_irq next edge.
- Simultaneous hardware event and W1C on the same bit: set wins, bit stays 1. SWSET and event on the same bit: bit = 1.
- Changing POL never fabricates an event; events come only from s2/s3 transitions.
- Warmup counter: loads WARMUP on reset and decrements to 0. Events are masked while it is nonzero, so a source held high through reset produces no PEND.
- Reset (synchronous, any time, including mid-transaction): all registers 0, s1/s2/s3 0, ack_o 0, dat_o 0, user_irq 0, warmup = WARMUP. An in-flight access is dropped without ack.

Test Plan:
- Reset, ENABLE=0x01, ROUTE=0, POL=0; raise irq_src_i[0] at edge E -> PEND=0x01 after E+2, user_irq=3'b001 after E+3. W1C 0x01 to PEND -> user_irq=0 on the edge after ack.
- POL[3]=1, ENABLE=0x08, ROUTE[7:6]=2; pulse irq_src_i[3] 1->0 -> user_irq=3'b100, STATUS=0x8000_0003. A rising edge on the same source leaves PEND unchanged.
- Source 5 event with ENABLE=0 -> PEND=0x20, user_irq=0. Write ENABLE=0x20 -> user_irq[ROUTE5] high one edge after ack. ROUTE5=3 -> deasserts.
- irq_src_i[2] held high through reset release -> PEND stays 0 after 10 cycles. Then drop and raise it -> PEND=0x04.
- Force source 1 event on the same cycle as a W1C of bit 1 -> PEND[1]=1 afterwards. SWSET=0x80 -> PEND[7]=1; read SWSET -> 0.
- Read offset 0x1C -> ack, data 0. Access with adr=0x3000_0100 -> no ack. Assert wb_rst_i the cycle after stb -> no ack, all outputs 0.
